// File: rtl/stopwatch_bcd_core.sv
// Four-digit BCD stopwatch core (00.00 .. 99.99 in hundredths of a second).
// Start/stop, clear and lap buttons are synchronised and debounced, a
// three-state FSM gates the prescaler, and a free-running divider produces
// the display scan clock. Define STOPWATCH_LAP_EN to build the lap freeze
// feature; without it btn_lap is ignored and digits always shows the live count.

module stopwatch_bcd_debounce #(
  parameter int DEB_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic pulse
);
  localparam int CW = $clog2(DEB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  logic          sync_meta;
  logic          sync_q;
  logic          level;
  logic          level_q;
  logic          armed;
  logic [1:0]    settle;
  logic [CW-1:0] cnt;

  // Synchronise, debounce, and arm edge detection once the input is seen low after reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_meta <= 1'b0;
      sync_q    <= 1'b0;
      level     <= 1'b0;
      level_q   <= 1'b0;
      armed     <= 1'b0;
      settle    <= 2'b00;
      cnt       <= '0;
    end else begin
      sync_meta <= raw;
      sync_q    <= sync_meta;
      level_q   <= level;
      settle    <= {settle[0], 1'b1};
      if (settle[1] && !sync_q) begin
        armed <= 1'b1;
      end
      if (sync_q != level) begin
        if (cnt == CNT_LAST) begin
          level <= sync_q;
          cnt   <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

  // A held-through-reset button never fires until it has been released once
  assign pulse = armed & level & ~level_q;
endmodule

module stopwatch_bcd_core #(
  parameter int TICK_DIV   = 1_000_000,
  parameter int DEB_CYCLES = 1_000_000,
  parameter int SCAN_DIV   = 100_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        btn_start,
  input  logic        btn_clear,
  input  logic        btn_lap,
  output logic [15:0] digits,
  output logic        running,
  output logic        scan_clk
);
  localparam int PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);
  localparam int SCAN_HALF = SCAN_DIV / 2;
  localparam int SW        = (SCAN_HALF > 1) ? $clog2(SCAN_HALF) : 1;
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_HALF - 1);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

  state_t        state;
  state_t        next_state;
  logic          start_p;
  logic          clear_p;
  logic          clear_cmd;
  logic          tick;
  logic [PW-1:0] presc;
  logic [3:0]    hund_units;
  logic [3:0]    hund_tens;
  logic [3:0]    sec_units;
  logic [3:0]    sec_tens;
  logic [15:0]   live;
  logic [SW-1:0] scan_cnt;

  stopwatch_bcd_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_start (
    .clk(clk), .reset(reset), .raw(btn_start), .pulse(start_p)
  );

  stopwatch_bcd_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_clear (
    .clk(clk), .reset(reset), .raw(btn_clear), .pulse(clear_p)
  );

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next state: clear beats start outside RUN, start beats clear inside RUN
  always_comb begin
    next_state = state;
    clear_cmd  = 1'b0;
    case (state)
      IDLE: begin
        if (clear_p) begin
          clear_cmd = 1'b1;
        end else if (start_p) begin
          next_state = RUN;
        end
      end
      RUN: begin
        if (start_p) begin
          next_state = PAUSE;
        end
      end
      PAUSE: begin
        if (clear_p) begin
          clear_cmd  = 1'b1;
          next_state = IDLE;
        end else if (start_p) begin
          next_state = RUN;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  assign running = (state == RUN);
  assign tick    = (state == RUN) && (presc == TICK_LAST);
  assign live    = {sec_tens, sec_units, hund_tens, hund_units};

  // Prescaler advances only in RUN and holds in PAUSE; each tick bumps the BCD count with carries
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc      <= '0;
      hund_units <= 4'd0;
      hund_tens  <= 4'd0;
      sec_units  <= 4'd0;
      sec_tens   <= 4'd0;
    end else if (clear_cmd) begin
      presc      <= '0;
      hund_units <= 4'd0;
      hund_tens  <= 4'd0;
      sec_units  <= 4'd0;
      sec_tens   <= 4'd0;
    end else if (state == RUN) begin
      if (tick) begin
        presc <= '0;
        if (hund_units == 4'd9) begin
          hund_units <= 4'd0;
          if (hund_tens == 4'd9) begin
            hund_tens <= 4'd0;
            if (sec_units == 4'd9) begin
              sec_units <= 4'd0;
              if (sec_tens == 4'd9) begin
                sec_tens <= 4'd0;
              end else begin
                sec_tens <= sec_tens + 4'd1;
              end
            end else begin
              sec_units <= sec_units + 4'd1;
            end
          end else begin
            hund_tens <= hund_tens + 4'd1;
          end
        end else begin
          hund_units <= hund_units + 4'd1;
        end
      end else begin
        presc <= presc + 1'b1;
      end
    end
  end

`ifdef STOPWATCH_LAP_EN
  logic        lap_p;
  logic        frozen;
  logic [15:0] snap;

  stopwatch_bcd_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_lap (
    .clk(clk), .reset(reset), .raw(btn_lap), .pulse(lap_p)
  );

  // Lap toggles the freeze outside IDLE, capturing the live count as it freezes
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frozen <= 1'b0;
      snap   <= 16'h0000;
    end else if (clear_cmd) begin
      frozen <= 1'b0;
    end else if (lap_p && (state != IDLE)) begin
      if (!frozen) begin
        snap <= live;
      end
      frozen <= !frozen;
    end
  end

  assign digits = frozen ? snap : live;
`else
  logic unused_lap;
  assign unused_lap = btn_lap;
  assign digits     = live;
`endif

  // Free-running scan divider, independent of the FSM
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scan_cnt <= '0;
      scan_clk <= 1'b0;
    end else if (scan_cnt == SCAN_LAST) begin
      scan_cnt <= '0;
      scan_clk <= ~scan_clk;
    end else begin
      scan_cnt <= scan_cnt + 1'b1;
    end
  end
endmodule
